// File: rtl/branch_predictor_gshare_if.sv
// Fetch/resolve bundle between the pipeline and the gshare predictor.
// Handshake: valid_E qualifies every Execute-side field in the same cycle. There is no ready,
// because the predictor takes an update in every cycle that valid_E and (branch_E or jump_E) are high.
interface branch_predictor_gshare_if #(
    parameter int PI = 10
);
    logic [31:0]   pc_F;
    logic [31:0]   pc4;
    logic [31:0]   pc_D;
    logic          valid_E;
    logic          branch_E;
    logic          jump_E;
    logic          branch;
    logic          taken_E;
    logic [PI-1:0] pht_idx_E;
    logic [31:0]   pc_E;
    logic [31:0]   pc4_E;
    logic [31:0]   pc_target;
    logic [31:0]   pc_next;
    logic          taken_F;
    logic [PI-1:0] pht_idx_F;
    logic          flush;
    logic [31:0]   pc_restore;
    logic [31:0]   perf_br;
    logic [31:0]   perf_miss;

    modport master (
        output pc_F, pc4, pc_D, valid_E, branch_E, jump_E, branch, taken_E, pht_idx_E,
               pc_E, pc4_E, pc_target,
        input  pc_next, taken_F, pht_idx_F, flush, pc_restore, perf_br, perf_miss
    );

    modport slave (
        input  pc_F, pc4, pc_D, valid_E, branch_E, jump_E, branch, taken_E, pht_idx_E,
               pc_E, pc4_E, pc_target,
        output pc_next, taken_F, pht_idx_F, flush, pc_restore, perf_br, perf_miss
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped BTB. It predicts combinationally in Fetch
// and trains from Execute, raising flush when a resolved branch or jump was mispredicted.
module branch_predictor_gshare #(
    parameter int BTB_ENTRIES = 256,
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_BITS    = 8,
    parameter int TAG_BITS    = 12
) (
    input logic                   clk,
    input logic                   rst,
    branch_predictor_gshare_if.slave bus
);
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int PI = $clog2(PHT_ENTRIES);

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]         btb_target [BTB_ENTRIES];
    logic                btb_kind   [BTB_ENTRIES];
    logic [1:0]          pht        [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         perf_br;
    logic [31:0]         perf_miss;

    logic [BI-1:0]       f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;
    logic [PI-1:0]       f_pht_idx;
    logic                f_taken;

    logic [BI-1:0]       e_idx;
    logic [TAG_BITS-1:0] e_tag;
    logic                upd;
    logic                is_br;
    logic                is_jmp;
    logic                btb_we;
    logic [1:0]          pht_cur;
    logic [1:0]          pht_new;
    logic                flush;
    logic [31:0]         pc_restore;
    logic                unused_ok;

    // Fetch: reads the registered state, so an entry written this cycle returns its old value.
    assign f_idx     = bus.pc_F[BI+1:2];
    assign f_tag     = bus.pc_F[BI+TAG_BITS+1:BI+2];
    assign f_hit     = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_pht_idx = bus.pc_F[PI+1:2] ^ PI'(ghr);
    assign f_taken   = f_hit && (btb_kind[f_idx] || pht[f_pht_idx][1]);

    assign bus.taken_F   = f_taken;
    assign bus.pht_idx_F = f_pht_idx;
    assign bus.pc_next   = f_taken ? btb_target[f_idx] : bus.pc4;

    // When branch_E and jump_E are both high, the instruction is handled as a branch.
    assign upd    = bus.valid_E && (bus.branch_E || bus.jump_E);
    assign is_br  = bus.branch_E;
    assign is_jmp = bus.jump_E && !bus.branch_E;
    assign btb_we = upd && (is_jmp || bus.branch);
    assign e_idx  = bus.pc_E[BI+1:2];
    assign e_tag  = bus.pc_E[BI+TAG_BITS+1:BI+2];

    assign pht_cur = pht[bus.pht_idx_E];

    always_comb begin
        pht_new = pht_cur;
        if (bus.branch) begin
            if (pht_cur != 2'b11) pht_new = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_new = pht_cur - 2'b01;
        end
    end

    always_comb begin
        flush      = 1'b0;
        pc_restore = 32'h0;
        if (upd) begin
            if (is_br) begin
                if (bus.taken_E != bus.branch) begin
                    flush      = 1'b1;
                    pc_restore = bus.branch ? bus.pc_target : bus.pc4_E;
                end else if (bus.branch && (bus.pc_D != bus.pc_target)) begin
                    flush      = 1'b1;
                    pc_restore = bus.pc_target;
                end
            end else if (bus.pc_D != bus.pc_target) begin
                flush      = 1'b1;
                pc_restore = bus.pc_target;
            end
        end
    end

    assign bus.flush      = flush;
    assign bus.pc_restore = pc_restore;
    assign bus.perf_br    = perf_br;
    assign bus.perf_miss  = perf_miss;

    // Reset takes priority so that a mid-run reset leaves no partial update behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
            ghr       <= '0;
            perf_br   <= 32'h0;
            perf_miss <= 32'h0;
        end else if (upd) begin
            if (btb_we) btb_valid[e_idx] <= 1'b1;
            if (is_br) begin
                pht[bus.pht_idx_E] <= pht_new;
                ghr <= (ghr << 1) | GHR_BITS'(bus.branch);
            end
            if (perf_br != 32'hFFFF_FFFF) perf_br <= perf_br + 32'd1;
            if (flush && (perf_miss != 32'hFFFF_FFFF)) perf_miss <= perf_miss + 32'd1;
        end
    end

    // Tag, target and kind are qualified by btb_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && btb_we) begin
            btb_tag[e_idx]    <= e_tag;
            btb_target[e_idx] <= bus.pc_target;
            btb_kind[e_idx]   <= is_jmp;
        end
    end

    assign unused_ok = ^{bus.pc_F, bus.pc_E};
endmodule
